// File: rtl/mon_fifo_pkg.sv
// mon_fifo_pkg
//   Shared definitions for the monitor data FIFO controller:
//   - arb_state_e : encoding of the two-state write/read arbiter
//   - DEF_DW/DEF_AW : default data and RAM address widths
package mon_fifo_pkg;

  typedef enum logic {
    WR_PRI = 1'b0,
    RD_PRI = 1'b1
  } arb_state_e;

  localparam int DEF_DW = 18;
  localparam int DEF_AW = 11;

endpackage

// File: rtl/mon_fifo_arb.sv
// mon_fifo_arb
//   Two-state arbiter between the FIFO writer and reader for the single RAM
//   port. Writes normally win. A write that wins over a pending read hands
//   priority to the read for the next cycle, so continuous contention
//   alternates W,R,W,R and the reader cannot starve.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (state -> WR_PRI)
//   wr_ok     : write request eligible (requested and FIFO not full)
//   rd_ok     : read request eligible (requested and FIFO not empty)
//   wr_gnt    : write granted this cycle
//   rd_gnt    : read granted this cycle (never together with wr_gnt)
//   state     : current arbiter state, exposed for debug
module mon_fifo_arb
  import mon_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ok,
  input  logic       rd_ok,
  output logic       wr_gnt,
  output logic       rd_gnt,
  output arb_state_e state
);

  arb_state_e state_q;
  arb_state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WR_PRI;
    else     state_q <= state_d;
  end

  // RD_PRI lasts exactly one cycle whatever happens in it; it only exists
  // to pay back a read that lost to a write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_PRI:  if (wr_ok && rd_ok) state_d = RD_PRI;
      RD_PRI:  state_d = WR_PRI;
      default: state_d = WR_PRI;
    endcase
  end

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    case (state_q)
      WR_PRI: begin
        wr_gnt = wr_ok;
        rd_gnt = rd_ok & ~wr_ok;
      end
      RD_PRI: begin
        rd_gnt = rd_ok;
        wr_gnt = wr_ok & ~rd_ok;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/mon_fifo_ctl.sv
// mon_fifo_ctl
//   Parametrised monitor data FIFO controller. Keeps read/write pointers,
//   arbitrates one external single-port synchronous RAM between writer and
//   reader and reports fill level / flags to the capture logic.
// Parameters: DW data width, AW RAM address width (depth 2**AW),
//   AFULL_TH almost_full threshold (level >= AFULL_TH).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   wrreq/wrack/wdata      : write request (held until wrack), accept, data
//   rdreq/rdack            : read request (held until rdack), accept
//   rvalid/rdata           : read data, valid the cycle after rdack
//   ram_ce/ram_we/ram_addr/ram_wdata/ram_rdata : external RAM port
//   empty/full/almost_full/level : FIFO status
//   arb_state              : arbiter state for debug (0 = WR_PRI, 1 = RD_PRI)
// Optional (macro MON_FIFO_STAT_EN):
//   stat_clr : clears ovf/udf/hwm (a same-cycle set condition wins)
//   ovf      : sticky, wrreq seen while full
//   udf      : sticky, rdreq seen while empty
//   hwm      : highest level seen since last clear
module mon_fifo_ctl
  import mon_fifo_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int AFULL_TH = 2**AW - 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrreq,
  output logic          wrack,
  input  logic [DW-1:0] wdata,
  input  logic          rdreq,
  output logic          rdack,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          arb_state
`ifdef MON_FIFO_STAT_EN
  ,
  input  logic          stat_clr,
  output logic          ovf,
  output logic          udf,
  output logic [AW:0]   hwm
`endif
);

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] AFULL_LVL = AFULL_TH[AW:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits coincide.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        rvalid_q;
  logic        wr_ok, rd_ok;
  logic        wr_gnt, rd_gnt;
  arb_state_e  state;

  assign empty       = (wptr_q == rptr_q);
  assign full        = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign level       = wptr_q - rptr_q;
  assign almost_full = (level >= AFULL_LVL);

  assign wr_ok = wrreq & ~full;
  assign rd_ok = rdreq & ~empty;

  mon_fifo_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .wr_ok  (wr_ok),
    .rd_ok  (rd_ok),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt),
    .state  (state)
  );

  assign arb_state = state;
  assign wrack     = wr_gnt;
  assign rdack     = rd_gnt;

  // RAM port: idle cycles park the address on the read pointer.
  assign ram_ce    = wr_gnt | rd_gnt;
  assign ram_we    = wr_gnt;
  assign ram_addr  = wr_gnt ? wptr_q[AW-1:0] : rptr_q[AW-1:0];
  assign ram_wdata = wdata;

  assign rvalid = rvalid_q;
  assign rdata  = ram_rdata;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_gnt) wptr_d = wptr_q + PTR_ONE;
    if (rd_gnt) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rvalid_q <= rd_gnt;
    end
  end

`ifdef MON_FIFO_STAT_EN
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  logic [AW:0] hwm_q, hwm_d;

  // Clear first, then apply set conditions so a same-cycle event survives.
  always_comb begin
    ovf_d = stat_clr ? 1'b0 : ovf_q;
    udf_d = stat_clr ? 1'b0 : udf_q;
    hwm_d = stat_clr ? '0 : hwm_q;
    if (wrreq && full)  ovf_d = 1'b1;
    if (rdreq && empty) udf_d = 1'b1;
    if (level > hwm_d)  hwm_d = level;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      hwm_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      hwm_q <= hwm_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_mon_fifo_ctl.sv
module tb_mon_fifo_ctl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          wrreq;
  logic          wrack;
  logic [DW-1:0] wdata;
  logic          rdreq;
  logic          rdack;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   level;
  logic          arb_state;
`ifdef MON_FIFO_STAT_EN
  logic          stat_clr;
  logic          ovf;
  logic          udf;
  logic [AW:0]   hwm;
`endif

  int n_chk;
  int n_fail;
  logic [DW-1:0] exp_q[$];

  mon_fifo_ctl #(.DW(DW), .AW(AW), .AFULL_TH(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .wrreq       (wrreq),
    .wrack       (wrack),
    .wdata       (wdata),
    .rdreq       (rdreq),
    .rdack       (rdack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .arb_state   (arb_state)
`ifdef MON_FIFO_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .ovf         (ovf),
    .udf         (udf),
    .hwm         (hwm)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port synchronous RAM model
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got e=%b f=%b af=%b exp e=1 f=0 af=0", empty, full, almost_full);
    end
    n_chk++; if (level !== 4'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d exp 0", level);
    end
    n_chk++; if (wrack !== 1'b0 || rdack !== 1'b0 || rvalid !== 1'b0 || ram_ce !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: got wrack=%b rdack=%b rvalid=%b ce=%b exp 0", wrack, rdack, rvalid, ram_ce);
    end
    n_chk++; if (arb_state !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got %b exp 0", arb_state);
    end
`ifdef MON_FIFO_STAT_EN
    n_chk++; if (ovf !== 1'b0 || udf !== 1'b0 || hwm !== 4'd0) begin
      n_fail++; $display("FAIL reset_stat: got ovf=%b udf=%b hwm=%0d exp 0", ovf, udf, hwm);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wrreq = 1'b1;
      wdata = 8'h10 + i[7:0];
      #1;
      n_chk++; if (wrack !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== i[2:0] || ram_wdata !== wdata) begin
        n_fail++; $display("FAIL fill_wr[%0d]: got ack=%b we=%b addr=%0d exp ack=1 we=1 addr=%0d", i, wrack, ram_we, ram_addr, i);
      end
      n_chk++; if (level !== i[3:0]) begin
        n_fail++; $display("FAIL fill_level[%0d]: got %0d exp %0d", i, level, i);
      end
      n_chk++; if (almost_full !== (i >= 6) || full !== 1'b0) begin
        n_fail++; $display("FAIL fill_af[%0d]: got af=%b full=%b exp af=%b full=0", i, almost_full, full, (i >= 6));
      end
    end
    @(negedge clk);
    wdata = 8'h18;
    #1;
    n_chk++; if (full !== 1'b1 || level !== 4'd8 || almost_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_full: got full=%b level=%0d af=%b exp 1/8/1", full, level, almost_full);
    end
    n_chk++; if (wrack !== 1'b0 || ram_ce !== 1'b0) begin
      n_fail++; $display("FAIL fill_ovf_ack: got wrack=%b ce=%b exp 0/0", wrack, ram_ce);
    end
    @(negedge clk);
    #1;
    n_chk++; if (wrack !== 1'b0 || level !== 4'd8 || ram_addr !== 3'd0) begin
      n_fail++; $display("FAIL fill_hold: got wrack=%b level=%0d addr=%0d exp 0/8/0", wrack, level, ram_addr);
    end
    wrreq = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdreq = 1'b1;
      #1;
      n_chk++; if (rdack !== 1'b1 || ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== i[2:0]) begin
        n_fail++; $display("FAIL drain_rd[%0d]: got ack=%b we=%b addr=%0d exp 1/0/%0d", i, rdack, ram_we, ram_addr, i);
      end
      n_chk++; if (level !== 4'(8 - i)) begin
        n_fail++; $display("FAIL drain_level[%0d]: got %0d exp %0d", i, level, 8 - i);
      end
      n_chk++; if (rvalid !== (i > 0)) begin
        n_fail++; $display("FAIL drain_rvalid[%0d]: got %b exp %b", i, rvalid, (i > 0));
      end
      if (i > 0) begin
        n_chk++; if (rdata !== 8'h10 + 8'(i - 1)) begin
          n_fail++; $display("FAIL drain_data[%0d]: got %0h exp %0h", i, rdata, 8'h10 + 8'(i - 1));
        end
      end
    end
    @(negedge clk);
    rdreq = 1'b0;
    #1;
    n_chk++; if (rvalid !== 1'b1 || rdata !== 8'h17) begin
      n_fail++; $display("FAIL drain_last: got v=%b d=%0h exp 1/17", rvalid, rdata);
    end
    n_chk++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got e=%b level=%0d f=%b exp 1/0/0", empty, level, full);
    end
    @(negedge clk);
    rdreq = 1'b1;
    #1;
    n_chk++; if (rdack !== 1'b0 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL drain_udf: got rdack=%b rvalid=%b exp 0/0", rdack, rvalid);
    end
    @(negedge clk);
    rdreq = 1'b0;
  endtask

`ifdef MON_FIFO_STAT_EN
  task automatic test_stat();
    #1;
    n_chk++; if (ovf !== 1'b1 || udf !== 1'b1 || hwm !== 4'd8) begin
      n_fail++; $display("FAIL stat_sticky: got ovf=%b udf=%b hwm=%0d exp 1/1/8", ovf, udf, hwm);
    end
    // clear together with a new underflow event: udf must stay set
    @(negedge clk);
    stat_clr = 1'b1;
    rdreq    = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    rdreq    = 1'b0;
    #1;
    n_chk++; if (ovf !== 1'b0 || udf !== 1'b1 || hwm !== 4'd0) begin
      n_fail++; $display("FAIL stat_set_wins: got ovf=%b udf=%b hwm=%0d exp 0/1/0", ovf, udf, hwm);
    end
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    n_chk++; if (ovf !== 1'b0 || udf !== 1'b0 || hwm !== 4'd0) begin
      n_fail++; $display("FAIL stat_clr: got ovf=%b udf=%b hwm=%0d exp 0/0/0", ovf, udf, hwm);
    end
  endtask
`endif

  task automatic test_contention();
    logic [DW-1:0] tail [3];
    tail = '{8'h22, 8'h30, 8'h31};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wrreq = 1'b1;
      wdata = 8'h20 + i[7:0];
      #1;
      n_chk++; if (wrack !== 1'b1) begin
        n_fail++; $display("FAIL cont_prefill[%0d]: got wrack=%b exp 1", i, wrack);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wrreq = 1'b1;
      rdreq = 1'b1;
      wdata = 8'h30 + 8'(k / 2);
      #1;
      n_chk++; if (wrack !== (k % 2 == 0) || rdack !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL cont_grant[%0d]: got wrack=%b rdack=%b exp %b/%b", k, wrack, rdack, (k % 2 == 0), (k % 2 == 1));
      end
      n_chk++; if (level !== ((k % 2 == 1) ? 4'd4 : 4'd3) || arb_state !== (k % 2 == 1)) begin
        n_fail++; $display("FAIL cont_level[%0d]: got level=%0d st=%b exp %0d/%b", k, level, arb_state, (k % 2 == 1) ? 4 : 3, (k % 2 == 1));
      end
      if (k == 2) begin
        n_chk++; if (rvalid !== 1'b1 || rdata !== 8'h20) begin
          n_fail++; $display("FAIL cont_data0: got v=%b d=%0h exp 1/20", rvalid, rdata);
        end
      end
    end
    @(negedge clk);
    wrreq = 1'b0;
    #1;
    n_chk++; if (rvalid !== 1'b1 || rdata !== 8'h21 || level !== 4'd3 || rdack !== 1'b1) begin
      n_fail++; $display("FAIL cont_data1: got v=%b d=%0h level=%0d rdack=%b exp 1/21/3/1", rvalid, rdata, level, rdack);
    end
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      if (j == 3) rdreq = 1'b0;
      #1;
      n_chk++; if (rvalid !== 1'b1 || rdata !== tail[j-1]) begin
        n_fail++; $display("FAIL cont_tail[%0d]: got v=%b d=%0h exp 1/%0h", j, rvalid, rdata, tail[j-1]);
      end
    end
    n_chk++; if (empty !== 1'b1) begin
      n_fail++; $display("FAIL cont_empty: got %b exp 1", empty);
    end
  endtask

  task automatic test_wrap();
    int phase_n [6];
    bit exp_full [6];
    bit exp_empty [6];
    logic [AW:0] exp_lvl [6];
    int wcnt;
    int rcnt;
    logic [DW-1:0] exp_d;
    phase_n   = '{8, 8, 8, 8, 4, 4};
    exp_full  = '{1, 0, 1, 0, 0, 0};
    exp_empty = '{0, 1, 0, 1, 0, 1};
    exp_lvl   = '{4'd8, 4'd0, 4'd8, 4'd0, 4'd4, 4'd0};
    wcnt = 0;
    rcnt = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < phase_n[p]; n++) begin
        if (p % 2 == 0) begin
          @(negedge clk);
          wrreq = 1'b1;
          wdata = 8'hA0 + 8'(wcnt);
          #1;
          n_chk++; if (wrack !== 1'b1 || ram_addr !== 3'(wcnt % 8)) begin
            n_fail++; $display("FAIL wrap_wr[%0d]: got ack=%b addr=%0d exp 1/%0d", wcnt, wrack, ram_addr, wcnt % 8);
          end
          exp_q.push_back(wdata);
          wcnt++;
        end else begin
          @(negedge clk);
          rdreq = 1'b1;
          #1;
          n_chk++; if (rdack !== 1'b1 || ram_addr !== 3'(rcnt % 8)) begin
            n_fail++; $display("FAIL wrap_rd[%0d]: got ack=%b addr=%0d exp 1/%0d", rcnt, rdack, ram_addr, rcnt % 8);
          end
          @(negedge clk);
          rdreq = 1'b0;
          #1;
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_chk++; if (rvalid !== 1'b1 || rdata !== exp_d) begin
            n_fail++; $display("FAIL wrap_data[%0d]: got v=%b d=%0h exp 1/%0h", rcnt, rvalid, rdata, exp_d);
          end
          rcnt++;
        end
      end
      if (p % 2 == 0) begin
        @(negedge clk);
        wrreq = 1'b0;
        #1;
      end
      n_chk++; if (full !== exp_full[p] || empty !== exp_empty[p] || level !== exp_lvl[p]) begin
        n_fail++; $display("FAIL wrap_flags[%0d]: got f=%b e=%b level=%0d exp %b/%b/%0d", p, full, empty, level, exp_full[p], exp_empty[p], exp_lvl[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wrreq = 1'b1;
      wdata = 8'h40 + i[7:0];
    end
    // write wins over the read here and hands priority to the reader
    @(negedge clk);
    rdreq = 1'b1;
    wdata = 8'h44;
    #1;
    n_chk++; if (wrack !== 1'b1 || rdack !== 1'b0 || level !== 4'd4) begin
      n_fail++; $display("FAIL rstmid_pre: got wrack=%b rdack=%b level=%0d exp 1/0/4", wrack, rdack, level);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (level !== 4'd5 || arb_state !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: got level=%0d st=%b exp 5/1", level, arb_state);
    end
    @(negedge clk);
    rst   = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    #1;
    n_chk++; if (level !== 4'd0 || empty !== 1'b1 || rvalid !== 1'b0 || arb_state !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_post: got level=%0d e=%b v=%b st=%b exp 0/1/0/0", level, empty, rvalid, arb_state);
    end
    @(negedge clk);
    wrreq = 1'b1;
    wdata = 8'h77;
    #1;
    n_chk++; if (wrack !== 1'b1 || ram_addr !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_restart: got wrack=%b addr=%0d exp 1/0", wrack, ram_addr);
    end
    @(negedge clk);
    wrreq = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    wdata  = '0;
`ifdef MON_FIFO_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_fill();
    test_drain();
`ifdef MON_FIFO_STAT_EN
    test_stat();
`endif
    test_contention();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
